// File: rtl/gate_sched_pkg.sv
// Shared types and helpers for the gate_op_scheduler block.
//   op_e        : 3-bit opcode of the shared bitwise logic unit
//   state_e     : IDLE -> EXEC -> RESP sequencing states
//   logic_eval  : evaluates one opcode over MAX_W-bit operands, returns {err, data}
//   calc_parity : XOR-reduction helper used by the optional parity output
package gate_sched_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_NOT     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XOR     = 3'd5,
        OP_XNOR    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Callers zero-extend narrower operands and keep only the low bits they need.
    function automatic logic [MAX_W:0] logic_eval(input op_e op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
        logic [MAX_W:0] res;
        case (op)
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_NOT:  res = {1'b0, ~a};
            OP_NAND: res = {1'b0, ~(a & b)};
            OP_NOR:  res = {1'b0, ~(a | b)};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_XNOR: res = {1'b0, ~(a ^ b)};
            default: res = {1'b1, {MAX_W{1'b0}}};
        endcase
        return res;
    endfunction

    function automatic logic calc_parity(input logic [MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/gate_op_scheduler_if.sv
// Request/response bundle between NUM_REQ requesters, one response consumer
// and the gate_op_scheduler.
//   req_valid/req_ready : per-requester handshake (one bit per requester)
//   req_op/req_a/req_b  : packed per-requester opcode and operands
//   rsp_*               : held response with valid/ready
//   master modport      : requester/consumer side; slave modport: scheduler side
// With GATE_OP_SCHEDULER_PARITY_EN defined, rsp_parity and req_parity_chk are added.
interface gate_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [3*NUM_REQ-1:0]      req_op;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
`ifdef GATE_OP_SCHEDULER_PARITY_EN
    logic                      rsp_parity;
    logic                      req_parity_chk;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, req_parity_chk,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_parity
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, req_parity_chk,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rsp_parity
    );
`else
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
`endif
endinterface

// File: rtl/gate_sched_rr_arb.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index for this search
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester (0 when no request)
module gate_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found_s;
    logic [ID_W-1:0] idx_s;

    // Scan from ptr upward with wrap; the first asserted request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Sequences one shared bitwise logic unit between NUM_REQ requesters:
// round-robin accept in IDLE, one registered EXEC cycle, then a held RESP.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_op_scheduler_if slave modport (requests and response)
//   busy : high in EXEC or RESP
// Optional macro GATE_OP_SCHEDULER_PARITY_EN adds rsp_parity (XOR of rsp_data).
module gate_op_scheduler
    import gate_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    gate_op_scheduler_if.slave  bus,
    output logic                busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e              state_r, state_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [ID_W-1:0]     ptr_r, id_r, ptr_next_s;
    logic [2:0]          op_r, sel_op_s;
    logic [DATA_W-1:0]   a_r, b_r, sel_a_s, sel_b_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                err_r, err_s;
    logic                accept_s;
`ifdef GATE_OP_SCHEDULER_PARITY_EN
    logic                parity_r;
`endif

    gate_sched_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Next-state decode; accept_s marks the request handshake edge.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_s  = EXEC;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Mux the granted requester's opcode and operands.
    always_comb begin
        sel_op_s = '0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == ID_W'(k)) begin
                sel_op_s = bus.req_op[3*k +: 3];
                sel_a_s  = bus.req_a[DATA_W*k +: DATA_W];
                sel_b_s  = bus.req_b[DATA_W*k +: DATA_W];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Evaluate the latched operation; only the low DATA_W bits are meaningful.
    always_comb begin
        data_s = DATA_W'(logic_eval(op_e'(op_r), MAX_W'(a_r), MAX_W'(b_r)));
        err_s  = 1'(logic_eval(op_e'(op_r), MAX_W'(a_r), MAX_W'(b_r)) >> MAX_W);
    end

    // Pointer moves just past the served requester.
    always_comb begin
        if (id_r == ID_W'(NUM_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = id_r + ID_W'(1);
        end
    end

    // State, latched request and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            id_r     <= '0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            data_r   <= '0;
            err_r    <= 1'b0;
`ifdef GATE_OP_SCHEDULER_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r <= sel_op_s;
                a_r  <= sel_a_s;
                b_r  <= sel_b_s;
                id_r <= grant_idx_s;
            end
            if (state_r == EXEC) begin
                data_r   <= data_s;
                err_r    <= err_s;
`ifdef GATE_OP_SCHEDULER_PARITY_EN
                parity_r <= calc_parity(MAX_W'(data_s));
`endif
            end
            if (state_r == RESP && bus.rsp_ready) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    assign bus.req_ready = (state_r == IDLE) ? grant_s : '0;
    assign bus.rsp_valid = (state_r == RESP);
    assign bus.rsp_id    = id_r;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_err   = err_r;
    assign busy          = (state_r != IDLE);
`ifdef GATE_OP_SCHEDULER_PARITY_EN
    assign bus.rsp_parity = parity_r;
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed self-checking bench for gate_op_scheduler (NUM_REQ=4, DATA_W=8).
module tb_gate_op_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   total_cnt = 0;
    int   bad_cnt   = 0;
    int   cyc_r     = 0;

    gate_op_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    gate_op_scheduler #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_r <= cyc_r + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with rsp_ready=1; returns at a negedge in IDLE.
    task automatic do_txn(input int idx, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e);
        logic [3:0] mask;
        mask = 4'b0000;
        mask[idx] = 1'b1;
        bus.req_valid = mask;
        bus.req_op[3*idx +: 3] = op;
        bus.req_a[8*idx +: 8]  = a;
        bus.req_b[8*idx +: 8]  = b;
        #1;
        check("txn_ready", 32'(bus.req_ready), 32'(mask));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_a[8*idx +: 8] = ~a;   // late operand change must not matter
        check("txn_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("txn_exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("txn_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("txn_rsp_id", 32'(bus.rsp_id), 32'(idx));
        check("txn_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
        check("txn_rsp_err", 32'(bus.rsp_err), 32'(exp_e));
`ifdef GATE_OP_SCHEDULER_PARITY_EN
        check("txn_rsp_parity", 32'(bus.rsp_parity), 32'(^exp_d));
`endif
        @(posedge clk);
        @(negedge clk);
        check("txn_idle", 32'(bus.rsp_valid), 32'd0);
    endtask

    logic [7:0] rr_exp_data [0:4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hFF};
    int         rr_exp_id   [0:4] = '{0, 1, 2, 3, 0};

    initial begin
        int k;
        int prev_cyc;
        bus.req_valid = 4'b0000;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
`ifdef GATE_OP_SCHEDULER_PARITY_EN
        bus.req_parity_chk = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // XOR from requester 1
        do_txn(1, 3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0);

        // Round robin from ptr=0 with all requesters continuously valid
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req_op[3*i +: 3] = 3'd5;
            bus.req_a[8*i +: 8]  = 8'(8'h11 * i);
            bus.req_b[8*i +: 8]  = 8'hFF;
        end
        bus.req_valid = 4'b1111;
        prev_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            k = 0;
            while (!bus.rsp_valid && k < 10) begin
                @(negedge clk);
                k++;
            end
            if (k >= 10) check("rr_timeout", 32'd0, 32'd1);
            check("rr_id", 32'(bus.rsp_id), 32'(rr_exp_id[n]));
            check("rr_data", 32'(bus.rsp_data), 32'(rr_exp_data[n]));
            if (n > 0) check("rr_spacing", 32'(cyc_r - prev_cyc), 32'd3);
            prev_cyc = cyc_r;
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        @(negedge clk);

        // NOT and illegal opcode from requester 2
        do_txn(2, 3'd2, 8'h5A, 8'hFF, 8'hA5, 1'b0);
        do_txn(2, 3'd7, 8'h5A, 8'hFF, 8'h00, 1'b1);

        // Backpressure: requester 0 held in RESP while requester 3 waits
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_op[2:0] = 3'd0;
        bus.req_a[7:0]  = 8'h0F;
        bus.req_b[7:0]  = 8'hFF;
        #1;
        check("bp_ready0", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        bus.req_op[11:9] = 3'd1;
        bus.req_a[31:24] = 8'h01;
        bus.req_b[31:24] = 8'h80;
        check("bp_exec_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_id", 32'(bus.rsp_id), 32'd0);
            check("bp_data", 32'(bus.rsp_data), 32'h0F);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_grant3", 32'(bus.req_ready), 32'h8);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("bp_r3_id", 32'(bus.rsp_id), 32'd3);
        check("bp_r3_data", 32'(bus.rsp_data), 32'h81);
        @(posedge clk);
        @(negedge clk);

        // Reset during EXEC: ptr is moved to 2 first, then requester 2 is aborted
        do_txn(1, 3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        bus.req_valid = 4'b0100;
        bus.req_op[8:6] = 3'd0;
        bus.req_a[23:16] = 8'hFF;
        bus.req_b[23:16] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rexec_valid", 32'(bus.rsp_valid), 32'd0);
        check("rexec_busy", 32'(busy), 32'd0);
        check("rexec_data", 32'(bus.rsp_data), 32'd0);
        check("rexec_id", 32'(bus.rsp_id), 32'd0);
        check("rexec_err", 32'(bus.rsp_err), 32'd0);
        repeat (3) @(negedge clk);
        check("rexec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid = 4'b1001;
        #1;
        check("rexec_ptr0", 32'(bus.req_ready), 32'h1);
        do_txn(0, 3'd6, 8'hAA, 8'h0F, 8'h5A, 1'b0);

`ifdef GATE_OP_SCHEDULER_PARITY_EN
        do_txn(0, 3'd0, 8'h07, 8'h03, 8'h03, 1'b0);
        do_txn(1, 3'd0, 8'h07, 8'h01, 8'h01, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Shares one bitwise logic unit between NUM_REQ requesters.
- The unit is AND, OR, NOT, NAND, NOR, XOR or XNOR over DATA_W-bit operands.
- Round-robin arbitration, a registered execute stage, and a held response with valid/ready.
- Sits between software-visible request ports and the gate-level logic datapath; it is the sole sequencer of that unit.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: operand/result width in bits (1..32).
- ID_W, $clog2(NUM_REQ): width of the requester index (derived; do not override).

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  NUM_REQ: per-requester request valid.
- req_ready  out  NUM_REQ: per-requester accept; at most one bit high, high only in IDLE.
- req_op  in  3*NUM_REQ: opcode per requester, slice i is [3i+2:3i].
- req_a  in  DATA_W*NUM_REQ: operand A per requester.
- req_b  in  DATA_W*NUM_REQ: operand B per requester.
- rsp_valid  out  1: response valid.
- rsp_ready  in  1: response consumer ready.
- rsp_id  out  ID_W: index of the requester served.
- rsp_data  out  DATA_W: result.
- rsp_err  out  1: illegal opcode flag.
- busy  out  1: high in EXEC or RESP.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is illegal: rsp_data=0, rsp_err=1.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant the first asserted index searching from ptr upward with wrap.
  - req_ready[grant]=1 combinationally in that same cycle; the handshake completes on that edge.
  - On the edge, latch op, a, b and id, then go to EXEC.
  - No valid: stay in IDLE, req_ready=0.
- EXEC: compute the result from the latched operands into the result register, then go to RESP. Exactly one cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: ptr <= (id+1) mod NUM_REQ, go to IDLE.
  - Backpressure holds RESP indefinitely; req_ready stays 0 throughout.
- Latency and throughput:
  - Accept at edge T gives rsp_valid high from cycle T+2.
  - Minimum three cycles per transaction.
- Fairness: a continuously requesting agent is served within NUM_REQ transactions.
- Requester-side timing:
  - req_valid deasserted before grant: no transaction.
  - Operand or opcode changes after acceptance do not affect the result.
- Reset:
  - Values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - Reset in EXEC or RESP discards the in-flight transaction with no response.
  - Reset wins over a simultaneous handshake.
- Widths: all logic is bitwise on DATA_W bits; no carries or extension.

Optional Feature:
- Macro: GATE_OP_SCHEDULER_PARITY_EN.
- When defined:
  - Adds output rsp_parity (1 bit) = XOR-reduction of rsp_data.
  - It is registered with the result, held with rsp_data, and 0 at reset.
  - Adds input req_parity_chk (1 bit); when high at accept, a latched-operand parity mismatch against a pre-latched expected bit is not used.
  - The parity output alone is the feature.
- When undefined: the port is absent and there is no logic.

Decomposition:
- Package gate_sched_pkg holds:
  - op_e enum: OP_AND..OP_XNOR, OP_ILLEGAL=7.
  - state_e enum: IDLE, EXEC, RESP.
  - Function logic_eval(op, a, b) returning {err, data}.
- One sub-module, gate_sched_rr_arb:
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.

Test Plan:
- Reset, then requester 1 sends op=5 (XOR), a=0xF0, b=0x3C, with rsp_ready=1 -> rsp_valid two cycles after accept, rsp_id=1, rsp_data=0xCC, rsp_err=0.
- All four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; each response three cycles apart.
- Requester 2 sends op=2 (NOT), a=0x5A, b=0xFF -> rsp_data=0xA5. Then op=7 -> rsp_data=0x00, rsp_err=1.
- rsp_ready held low for 5 cycles during RESP while requester 3 is valid -> rsp_* stable, req_ready all 0, busy=1; requester 3 is granted only after the handshake.
- rst asserted in EXEC -> next cycle all outputs 0, no response; the following request from requester 0 is served normally with ptr=0.
- With GATE_OP_SCHEDULER_PARITY_EN: op=0 (AND), a=0x07, b=0x03 -> rsp_data=0x03, rsp_parity=0.
